// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception vector offsets, interrupt exception code
// and the interrupt-line index type used by the interrupt controller.
package cp0_pkg;

  localparam logic [31:0] OFF_GENERAL = 32'h0000_0180;
  localparam logic [31:0] OFF_INT     = 32'h0000_0200;
  localparam logic [4:0]  EXCCODE_INT = 5'd0;

  // Line indices are carried at a fixed width wide enough for up to 32 lines.
  localparam int MAX_LINES = 32;
  typedef logic [$clog2(MAX_LINES)-1:0] int_line_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with a programmable prescaler and a sticky
// timer-interrupt flag that only a Compare write clears.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int CNT_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_count_we,
  input  logic [CNT_W-1:0] i_count_wd,
  input  logic             i_compare_we,
  input  logic [CNT_W-1:0] i_compare_wd,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_compare,
  output logic             o_ti
);

  localparam int              DIV_W    = clog2_min1(CNT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_compare;
  logic             r_ti;
  logic             w_tick;

  assign w_tick = (r_div == DIV_LAST);

  // A Count write restarts the prescaler phase and swallows that cycle's tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_count_we) begin
        r_div   <= '0;
        r_count <= i_count_wd;
      end else if (w_tick) begin
        r_div   <= '0;
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_div   <= r_div + DIV_W'(1);
      end

      if (i_compare_we) begin
        r_compare <= i_compare_wd;
      end

      if (i_compare_we) begin
        r_ti <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: line sampling, masking, priority encoding, held
// request and vector offset. Define CP0_INTC_VINT_EN for vectored interrupts.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          N_EXT       = 6,
  parameter int          N_SW        = 2,
  parameter int          CNT_W       = 32,
  parameter int          CNT_DIV     = 2,
  parameter logic [31:0] VEC_SPACING = 32'h20,
  localparam int         L           = N_SW + N_EXT,
  localparam int         LINE_W      = clog2_min1(L)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_EXT-1:0]  i_ext_int,
  input  logic              i_sw_ip_we,
  input  logic [N_SW-1:0]   i_sw_ip_wd,
  input  logic [L-1:0]      i_im,
  input  logic              i_ie,
  input  logic              i_exl,
  input  logic              i_iv,
  input  logic              i_count_we,
  input  logic [CNT_W-1:0]  i_count_wd,
  input  logic              i_compare_we,
  input  logic [CNT_W-1:0]  i_compare_wd,
  input  logic              i_take,
  output logic              o_int_req,
  output logic              o_int_taken,
  output logic [L-1:0]      o_ip,
  output logic              o_ti,
  output logic [CNT_W-1:0]  o_count,
  output logic [CNT_W-1:0]  o_compare,
  output logic [LINE_W-1:0] o_int_line,
  output logic [31:0]       o_vec_offset
);

  logic [N_EXT-1:0] r_ext_q;
  logic [N_SW-1:0]  r_sw_q;
  logic             r_held;
  logic             w_ti;
  logic [L-1:0]     w_ip;
  logic [L-1:0]     w_pend;
  logic             w_irq;
  int_line_t        w_line;

  cp0_timer #(
    .CNT_W   (CNT_W),
    .CNT_DIV (CNT_DIV)
  ) u_timer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_count_we   (i_count_we),
    .i_count_wd   (i_count_wd),
    .i_compare_we (i_compare_we),
    .i_compare_wd (i_compare_wd),
    .o_count      (o_count),
    .o_compare    (o_compare),
    .o_ti         (w_ti)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ext_q <= '0;
      r_sw_q  <= '0;
    end else begin
      r_ext_q <= i_ext_int;
      if (i_sw_ip_we) begin
        r_sw_q <= i_sw_ip_wd;
      end
    end
  end

  // The request stays held until a commit slot takes it, even if the source drops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_held <= 1'b0;
    end else if (i_take) begin
      r_held <= 1'b0;
    end else if (w_irq) begin
      r_held <= 1'b1;
    end
  end

  always_comb begin
    w_ip        = {r_ext_q, r_sw_q};
    w_ip[L-1]   = w_ip[L-1] | w_ti;
    w_pend      = w_ip & i_im;
    w_irq       = i_ie && !i_exl && (|w_pend);
    w_line      = '0;
    for (int i = 0; i < L; i++) begin
      if (w_pend[i]) begin
        w_line = int_line_t'(i);
      end
    end
  end

  always_comb begin
    o_vec_offset = OFF_GENERAL;
`ifdef CP0_INTC_VINT_EN
    if (i_iv) begin
      o_vec_offset = OFF_INT + (32'(w_line) * VEC_SPACING);
    end
`else
    if (i_iv) begin
      o_vec_offset = OFF_INT;
    end
`endif
  end

  assign o_int_req   = w_irq || r_held;
  assign o_int_taken = o_int_req && i_take;
  assign o_ip        = w_ip;
  assign o_ti        = w_ti;
  assign o_int_line  = w_line[LINE_W-1:0];

endmodule

// File: doc/cp0_intc.md
# cp0_intc

Parametrised interrupt and timer controller for CP0, generalising the fixed 6-external/2-software interrupt and count/compare logic into a standalone block. Owns the count/compare timer with programmable prescaler, the sticky timer-interrupt flag, the sampled and masked interrupt-pending vector, and the held interrupt request presented to the pipeline until a commit slot takes it. Sits beside the CP0 register file. CP0 supplies Status/Cause control bits and consumes the request, pending bits and exception vector offset.

## Interface
- N_EXT, 6, number of external interrupt lines
- N_SW, 2, number of software interrupt bits; L = N_SW + N_EXT total lines
- CNT_W, 32, count/compare width
- CNT_DIV, 2, clk cycles per count increment (>=1)
- VEC_SPACING, 32'h20, per-line vector stride (vectored mode only)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ext_int  in  N_EXT  level-sensitive external lines
- sw_ip_we  in  1  write strobe for software pending bits
- sw_ip_wd  in  N_SW  software pending write data
- im  in  L  Status.IM mask
- ie  in  1  Status.IE
- exl  in  1  Status.EXL
- iv  in  1  Cause.IV
- count_we  in  1  Count write strobe
- count_wd  in  CNT_W  Count write data
- compare_we  in  1  Compare write strobe
- compare_wd  in  CNT_W  Compare write data
- take  in  1  pipeline has a valid commit slot to take an interrupt
- int_req  out  1  interrupt request, pending or held
- int_taken  out  1  int_req && take
- ip  out  L  Cause.IP view, timer ORed into bit L-1
- ti  out  1  sticky timer-interrupt flag
- count  out  CNT_W  current Count
- compare  out  CNT_W  current Compare
- int_line  out  $clog2(L)  highest-index pending unmasked line
- vec_offset  out  32  exception vector offset for an interrupt

## Operation
- Sampling: ext_int is registered every cycle. ip = {ext_q, sw_q}, with bit L-1 additionally ORed with ti.
- Software bits: sw_q is loaded from sw_ip_wd on sw_ip_we and is otherwise held.
- Prescaler: div counts 0..CNT_DIV-1 and wraps to 0. count increments when div == CNT_DIV-1. count wraps from 2^CNT_W-1 to 0.
- count_we: loads count_wd, suppresses that cycle's increment, and resets div to 0.
- Timer flag: ti sets when the registered count equals compare. It stays set until compare_we. If compare_we coincides with a match, the clear wins.
- Raw interrupt: irq = ie && !exl && |(ip & im).
- Hold flag held:
  - sets when irq && !take
  - clears when take
  - otherwise holds
  - It is not cleared by the source deasserting or by ie/exl changes.
- int_req = irq || held.
- int_line: the highest index i with ip[i] & im[i]. It is 0 when none is pending.

## Timing
- Reset values: count 0, compare 0, ti 0, div 0, sw_q 0, ext_q 0, held 0. Therefore int_req 0, ip 0, int_line 0, and vec_offset 0x180 (iv=0).
- ext_int to ip: 1 cycle. ip to int_req: combinational.
- compare_we / count_we take effect at the next edge. ti reflects a match one cycle after count reaches compare.
- int_taken, int_req, int_line and vec_offset are combinational from state and inputs. There is no extra latency.
- Simultaneous sw_ip_we and take: the take applies to the pre-write state, and the new bits are visible next cycle.
- Reset mid-operation clears all state, including held, on the same edge.

## Configuration
- CP0_INTC_VINT_EN defined (vectored mode):
  - vec_offset = 0x200 + int_line*VEC_SPACING when iv=1
  - vec_offset = 0x180 when iv=0
- CP0_INTC_VINT_EN undefined: vec_offset = iv ? 0x200 : 0x180. int_line is still driven.

## Structure
- The cp0_pkg shared package holds:
  - vector offset constants OFF_GENERAL=0x180 and OFF_INT=0x200
  - EXCCODE_INT
  - the interrupt-line index type
- Sub-module cp0_timer holds div, count, compare, ti and their write strobes, and is parametrised by CNT_W and CNT_DIV.
- The top level holds sampling, masking, priority encoding, the hold flag and vector generation.

## Test plan
- Timer match: CNT_DIV=2, compare=5, count written 0 → ti=1 by cycle 11 and stays 1. compare_we → ti=0 next cycle.
- Count wrap: CNT_W=8, count=0xFF → next increment gives count=0x00 with no spurious ti when compare=0x80.
- Held request: ie=1, exl=0, im[2]=1, ext_int[0] pulsed for 1 cycle, take=0 → int_req stays 1 after the pulse. take=1 → int_taken=1, and int_req=0 the next cycle.
- Masking: exl=1 with an active unmasked line → int_req=0 and held stays 0.
- Priority and vectoring: with VINT_EN, iv=1, lines 3 and 6 pending and unmasked → int_line=6 and vec_offset=0x2C0.
- Simultaneous count_we and tick: count_wd=0x10 → count=0x10, with no increment that cycle.
